ifid_skid_latch: RTL and testbench

- Next-generation IF→ID pipeline register. Replaces the fixed 32-bit instrD/PCplus4D latch.
- Adds parametrised widths and a valid/ready handshake on both sides.
- A 2-entry skid buffer keeps fetch from losing beats when decode back-pressures.
- Stall/flush priority is selectable, and saturating stall/flush counters are provided for debug.

---
 rtl/ifid_skid_latch.sv | 149 ++++++++++++++
 tb/tb_ifid_skid_latch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ifid_skid_latch.sv
// IF->ID pipeline register with valid/ready handshake, 2-entry skid buffer,
// selectable stall/flush priority and saturating debug counters.
module ifid_skid_latch #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned BUBBLE     = 0,
    parameter int unsigned CNT_W      = 16,
    parameter bit          STALL_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instrF,
    input  logic [PC_W-1:0]   PCplus4F,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] instrD,
    output logic [PC_W-1:0]   PCplus4D,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    input  logic              cnt_clr
);

    localparam logic [DATA_W-1:0] BUBBLE_INSTR = DATA_W'(BUBBLE);
    localparam logic [PC_W-1:0]   BUBBLE_PC    = PC_W'(BUBBLE);
    localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]   main_pc_q,    main_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;
    logic              flush_pend_q, flush_pend_d;
    logic              in_ready_q,   in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;

    logic take;
    logic give;
    logic flush_req;
    logic flush_apply;

    assign take = in_valid & in_ready_q;
    assign give = main_valid_q & out_ready & ~stall;

    always_comb begin
        main_valid_d = main_valid_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        flush_req    = flush | flush_pend_q;

        // With stall priority a flush seen under stall is parked until stall drops.
        if (STALL_PRIO) begin
            flush_apply  = flush_req & ~stall;
            flush_pend_d = flush_req & stall;
        end else begin
            flush_apply  = flush;
            flush_pend_d = 1'b0;
        end

        if (flush_apply) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (give) begin
                main_valid_d = 1'b1;
                main_instr_d = skid_instr_q;
                main_pc_d    = skid_pc_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q) begin
            if (give && take) begin
                main_instr_d = instrF;
                main_pc_d    = PCplus4F;
            end else if (give) begin
                main_valid_d = 1'b0;
            end else if (take) begin
                skid_valid_d = 1'b1;
                skid_instr_d = instrF;
                skid_pc_d    = PCplus4F;
            end
        end else if (take) begin
            main_valid_d = 1'b1;
            main_instr_d = instrF;
            main_pc_d    = PCplus4F;
        end

        in_ready_d = ~skid_valid_d & ~flush_pend_d;

        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (main_valid_q && stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        if (cnt_clr) begin
            flush_cnt_d = '0;
        end else if (flush_apply && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            main_instr_q <= BUBBLE_INSTR;
            main_pc_q    <= BUBBLE_PC;
            skid_valid_q <= 1'b0;
            skid_instr_q <= BUBBLE_INSTR;
            skid_pc_q    <= BUBBLE_PC;
            flush_pend_q <= 1'b0;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            flush_pend_q <= flush_pend_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign instrD    = main_valid_q ? main_instr_q : BUBBLE_INSTR;
    assign PCplus4D  = main_valid_q ? main_pc_q : BUBBLE_PC;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ifid_skid_latch.sv
// Bench for ifid_skid_latch: two instances (flush-priority/16-bit counters and
// stall-priority/4-bit counters) share stimulus and are checked against a FIFO model.
module tb_ifid_skid_latch;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, stall, flush, out_ready, cnt_clr;
    logic [31:0] instrF, PCplus4F;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_instrD, a_PCplus4D;
    logic [1:0]  a_occ;
    logic [15:0] a_scnt, a_fcnt;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_instrD, b_PCplus4D;
    logic [1:0]  b_occ;
    logic [3:0]  b_scnt, b_fcnt;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: each instance is an in-order queue of {pc, instr}, max depth 2.
    logic [63:0] mq [2][$];
    int pend [2];
    int scnt [2];
    int fcnt [2];
    int cmax [2] = '{65535, 15};
    int prio [2] = '{0, 1};

    always #5 clk = ~clk;

    ifid_skid_latch #(.DATA_W(32), .PC_W(32), .BUBBLE(0), .CNT_W(16), .STALL_PRIO(1'b0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .instrF(instrF), .PCplus4F(PCplus4F), .stall(stall), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .instrD(a_instrD),
        .PCplus4D(a_PCplus4D), .occupancy(a_occ), .stall_cnt(a_scnt),
        .flush_cnt(a_fcnt), .cnt_clr(cnt_clr)
    );

    ifid_skid_latch #(.DATA_W(32), .PC_W(32), .BUBBLE(0), .CNT_W(4), .STALL_PRIO(1'b1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .instrF(instrF), .PCplus4F(PCplus4F), .stall(stall), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .instrD(b_instrD),
        .PCplus4D(b_PCplus4D), .occupancy(b_occ), .stall_cnt(b_scnt),
        .flush_cnt(b_fcnt), .cnt_clr(cnt_clr)
    );

    task automatic chk(string tag, int d, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            pend[d] = 0;
            scnt[d] = 0;
            fcnt[d] = 0;
        end
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_clear();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            bit ready, tk, ov, gv, freq, fapply;
            ready = (mq[d].size() < 2) && (pend[d] == 0);
            tk    = in_valid && ready;
            ov    = mq[d].size() > 0;
            gv    = ov && out_ready && !stall;
            if (prio[d] != 0) begin
                freq    = flush || (pend[d] != 0);
                fapply  = freq && !stall;
                pend[d] = (freq && stall) ? 1 : 0;
            end else begin
                fapply  = flush;
                pend[d] = 0;
            end
            if (cnt_clr) scnt[d] = 0;
            else if (ov && stall && scnt[d] < cmax[d]) scnt[d]++;
            if (cnt_clr) fcnt[d] = 0;
            else if (fapply && fcnt[d] < cmax[d]) fcnt[d]++;
            if (fapply) begin
                mq[d].delete();
            end else begin
                if (gv) void'(mq[d].pop_front());
                if (tk) mq[d].push_back({PCplus4F, instrF});
            end
        end
    endtask

    task automatic check_dut(int d, logic rdy, logic ov, logic [31:0] ins, logic [31:0] pc,
                             logic [1:0] occ, logic [15:0] sc, logic [15:0] fc);
        int          sz;
        logic [63:0] head;
        sz   = mq[d].size();
        head = (sz > 0) ? mq[d][0] : 64'd0;
        chk("in_ready",  d, {63'd0, rdy}, ((sz < 2) && (pend[d] == 0)) ? 64'd1 : 64'd0);
        chk("out_valid", d, {63'd0, ov},  (sz > 0) ? 64'd1 : 64'd0);
        chk("instrD",    d, {32'd0, ins}, {32'd0, head[31:0]});
        chk("PCplus4D",  d, {32'd0, pc},  {32'd0, head[63:32]});
        chk("occupancy", d, {62'd0, occ}, 64'(sz));
        chk("stall_cnt", d, {48'd0, sc},  64'(scnt[d]));
        chk("flush_cnt", d, {48'd0, fc},  64'(fcnt[d]));
    endtask

    task automatic check_all();
        check_dut(0, a_in_ready, a_out_valid, a_instrD, a_PCplus4D, a_occ, a_scnt, a_fcnt);
        check_dut(1, b_in_ready, b_out_valid, b_instrD, b_PCplus4D, b_occ, {12'd0, b_scnt}, {12'd0, b_fcnt});
    endtask

    // Check before the edge, advance the model on the edge, leave time just after it.
    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic beat(logic [31:0] ins);
        in_valid = 1'b1;
        instrF   = ins;
        PCplus4F = ins + 32'h1000;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        out_ready = 1'b0; cnt_clr = 1'b0; instrF = '0; PCplus4F = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // Streaming: four beats back to back with decode always ready.
        out_ready = 1'b1;
        beat(32'h11); tick();
        beat(32'h22); tick();
        beat(32'h33); tick();
        beat(32'h44); tick();
        in_valid = 1'b0; tick(); tick();

        // Back-pressure fills the skid, then drains in order.
        out_ready = 1'b0;
        beat(32'hA); tick();
        beat(32'hB); tick();
        in_valid = 1'b0; tick();
        out_ready = 1'b1; tick(); tick(); tick();

        // Flush under stall with a full buffer and a concurrent beat.
        out_ready = 1'b0;
        beat(32'h1); tick();
        beat(32'h2); tick();
        stall = 1'b1; flush = 1'b1; beat(32'hC); tick();
        in_valid = 1'b0; tick(); tick();
        flush = 1'b0; stall = 1'b0; tick(); tick();

        // Stall counter saturation, then clear.
        out_ready = 1'b1;
        beat(32'h55); tick();
        in_valid = 1'b0; stall = 1'b1;
        repeat (20) tick();
        cnt_clr = 1'b1; tick();
        cnt_clr = 1'b0; stall = 1'b0; tick(); tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(99, 0) < 70);
            out_ready = ($urandom_range(99, 0) < 60);
            stall     = ($urandom_range(99, 0) < 20);
            flush     = ($urandom_range(99, 0) < 5);
            cnt_clr   = ($urandom_range(99, 0) < 2);
            instrF    = $urandom;
            PCplus4F  = $urandom;
            tick();
        end

        // Asynchronous reset with the buffer full.
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b0;
        tick(); tick();
        beat(32'hD1); tick();
        beat(32'hD2); tick();
        in_valid = 1'b0; tick();
        #2 reset = 1'b0;
        #1;
        model_clear();
        check_all();
        tick();
        reset = 1'b1;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
